// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, PC/instruction FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_stall_cnt and redirect_cnt outputs.
module mips_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt,
    output logic [15:0] redirect_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d, count_after;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic          push;
    logic          pop;

    assign pop         = (count_q != '0) && instr_ready;
    assign count_after = count_q + CW'(1) - CW'(pop);

    // Fetch FSM: next state, next fetch PC, next request address, push strobe
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < FULL) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_ack) begin
                        addr_d = redirect_pc;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd1;
                    if (count_after < FULL) begin
                        addr_d = fetch_pc_q + 32'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a redirect empties the buffer and wins over push/pop
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req    = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] redir_cnt_q;

    // Stall cycles saturate; redirect count wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (!instr_valid && (state_q != IDLE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
    assign redirect_cnt    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: random memory latency, backpressure and redirects,
// checked against an in-order PC stream model (restarted at every redirect or reset).
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
    logic [15:0] redirect_cnt;
`endif

    mips_fetch_unit #(
        .DEPTH   (4),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt(fetch_stall_cnt),
        .redirect_cnt   (redirect_cnt)
`endif
    );

    always #5 clock = ~clock;

    int          checks;
    int          errors;
    int          consumed;
    int          redir_count;
    logic [63:0] exp_q [$];
    logic [31:0] acked [$];
    logic [31:0] next_pc;

    // Memory responder controls
    logic        resp_en;
    logic        resp_rand;
    int          resp_lat;
    logic        resp_ack;
    logic [31:0] resp_data;
    logic        inj_ack;
    logic [31:0] inj_data;
    int          wait_n;
    int          cur_lat;

    assign imem_ack   = resp_ack | inj_ack;
    assign imem_rdata = inj_ack ? inj_data : resp_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 16) begin
            exp_q.push_back({next_pc, mem_word(next_pc)});
            next_pc = next_pc + 32'd1;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        topup();
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        topup();
    endtask

    task automatic reset_checks();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cnt", fetch_stall_cnt, 32'd0);
        chk("rst_redir_cnt", 32'(redirect_cnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        redirect = 1'b0;
        inj_ack  = 1'b0;
        restart(RESET_PC);
        redir_count = 0;
        #1;
        reset_checks();
        step();
        acked.delete();
        reset_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart(pc);
        redir_count++;
    endtask

    // Memory model: acks the outstanding request after a chosen latency
    always @(posedge clock) begin
        #1;
        if (!reset_n || !resp_en || !imem_req) begin
            resp_ack = 1'b0;
            wait_n   = 0;
        end else begin
            if (wait_n == 0) begin
                cur_lat = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
            end
            if (wait_n >= cur_lat) begin
                resp_ack  = 1'b1;
                resp_data = mem_word(imem_addr);
                acked.push_back(imem_addr);
                wait_n    = 0;
            end else begin
                resp_ack = 1'b0;
                wait_n++;
            end
        end
    end

    // Monitor: request-hold protocol and consumed instruction stream
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [63:0] ent;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    ent = exp_q.pop_front();
                    chk("instr_pc", instr_pc, ent[63:32]);
                    chk("instr", instr, ent[31:0]);
                    consumed++;
                end
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    logic [31:0] wrap_exp [3];

    initial begin
        clock = 1'b0; reset_n = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        inj_ack = 1'b0; inj_data = '0; resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 0;
        resp_ack = 1'b0; resp_data = '0; wait_n = 0; cur_lat = 0;
        checks = 0; errors = 0; consumed = 0; redir_count = 0; next_pc = '0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; ent = '0;
        wrap_exp[0] = 32'hFFFF_FFFF; wrap_exp[1] = 32'h0; wrap_exp[2] = 32'h1;
        #1;

        // Sequential fetch, ack one cycle after each request
        resp_lat = 1; instr_ready = 1'b1;
        do_reset();
        step();
        chk("req_first_edge", 32'(imem_req), 32'd1);
        chk("addr_first", imem_addr, RESET_PC);
        for (int i = 0; i < 40 && acked.size() < 4; i++) step();
        chk("seq_acks", 32'(acked.size()), 32'd4);
        if (acked.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("seq_addr", acked[k], 32'(k));
        end

        // Backpressure fills the buffer, then drains and resumes at 4
        resp_lat = 0; instr_ready = 1'b0;
        do_reset();
        repeat (12) step();
        chk("full_req_low", 32'(imem_req), 32'd0);
        chk("full_acks", 32'(acked.size()), 32'd4);
        chk("full_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && acked.size() < 5; i++) step();
        chk("resume_acks", 32'(acked.size()), 32'd5);
        if (acked.size() >= 5) chk("resume_addr", acked[4], 32'd4);
        repeat (6) step();

        // Redirect while a slow request is outstanding: old data dropped
        resp_lat = 3;
        do_reset();
        for (int i = 0; i < 80 && !(imem_req && imem_addr == 32'd5); i++) step();
        chk("reach_addr5", imem_addr, 32'd5);
        step();
        do_redirect(32'h40);
        acked.delete();
        step();
        redirect = 1'b0;
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'd5);
        for (int i = 0; i < 20 && acked.size() < 2; i++) step();
        chk("drop_acks", 32'(acked.size()), 32'd2);
        if (acked.size() >= 2) begin
            chk("drop_old", acked[0], 32'd5);
            chk("drop_new", acked[1], 32'h40);
        end
        repeat (12) step();

        // Redirect coinciding with ack and pop while two entries are buffered
        resp_lat = 0; instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && acked.size() < 3; i++) step();
        chk("d_acks", 32'(acked.size()), 32'd3);
        chk("d_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        do_redirect(32'h1000);
        step();
        redirect = 1'b0;
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h1000);
        repeat (10) step();

        // PC wrap at the top of the address space, one instruction per cycle
        do_reset();
        repeat (3) step();
        do_redirect(32'hFFFF_FFFF);
        acked.delete();
        step();
        redirect = 1'b0;
        for (int i = 0; i < 20 && acked.size() < 3; i++) step();
        chk("wrap_acks", 32'(acked.size()), 32'd3);
        if (acked.size() >= 3) begin
            for (int k = 0; k < 3; k++) chk("wrap_addr", acked[k], wrap_exp[k]);
        end
        repeat (3) begin
            step();
            chk("stream_valid", 32'(instr_valid), 32'd1);
        end
        repeat (4) step();

        // Reset mid-request, stale ack right after release is ignored
        resp_lat = 20;
        do_reset();
        repeat (4) step();
        chk("f_wait_req", 32'(imem_req), 32'd1);
        resp_en = 1'b0;
        reset_n = 1'b0;
        restart(RESET_PC);
        redir_count = 0;
        #1;
        reset_checks();
        step();
        reset_n  = 1'b1;
        inj_ack  = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        step();
        inj_ack = 1'b0;
        chk("stale_req", 32'(imem_req), 32'd1);
        chk("stale_addr", imem_addr, RESET_PC);
        chk("stale_valid", 32'(instr_valid), 32'd0);
        resp_en = 1'b1; resp_lat = 0;
        repeat (10) step();

        // Random latency, backpressure and redirects
        resp_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            step();
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0: do_redirect($urandom);
                    1: do_redirect(32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
                    default: do_redirect(32'($urandom_range(0, 255)));
                endcase
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        redirect = 1'b0; instr_ready = 1'b1;
        repeat (20) step();
        chk("progress", 32'(consumed > 200), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("redirect_cnt", 32'(redirect_cnt), 32'(16'(redir_count)));
        chk("stall_cnt_nonzero", 32'(fetch_stall_cnt != 32'd0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
